// File: rtl/rc5_pkg.sv
// ---------------------------------------------------------------------------
// rc5_pkg
// Shared constants and the state encoding for the RC5 S-table consumer.
//   W          word width
//   R          round count
//   T          S-table depth (2*R+2)
//   ROT_BITS   rotate-amount width (log2 W)
//   AW         S RAM address width
//   START_ADDR first address read by a decrypt (T-1); also the last one
//              read by an encrypt
//   FINAL_ADDR lowest address used by the rounds (2)
// Optional build macro: RC5_ENC_EN (adds the encrypt direction).
// ---------------------------------------------------------------------------
package rc5_pkg;

   localparam int W        = 32;
   localparam int R        = 12;
   localparam int T        = 2 * R + 2;
   localparam int ROT_BITS = $clog2(W);
   localparam int AW       = $clog2(T);

   localparam logic [AW-1:0] START_ADDR = AW'(T - 1);
   localparam logic [AW-1:0] FINAL_ADDR = AW'(2);

   typedef enum logic [3:0] {
      IDLE    = 4'd0,
      ADDR_B  = 4'd1,
      CALC_B  = 4'd2,
      ADDR_A  = 4'd3,
      CALC_A  = 4'd4,
      ADDR_F1 = 4'd5,
      FIN_B   = 4'd6,
      ADDR_F0 = 4'd7,
      FIN_A   = 4'd8,
      DONE    = 4'd9
   } state_t;

endpackage

// File: rtl/rc5_decrypt_core_if.sv
// ---------------------------------------------------------------------------
// rc5_decrypt_core_if
// Bundles the block request/result signals and the S RAM read port.
//   iStart/iA/iB     request and ciphertext words (master -> core)
//   iEncrypt         direction select, only with RC5_ENC_EN
//   oS_address       S RAM read address (core -> RAM)
//   iS_sub_i         S RAM read data, one cycle after the address
//   oA/oB            result words
//   oBusy/oDone      status and one-cycle completion pulse
// Modports: master (system/bench side), slave (the core).
// Optional build macro: RC5_ENC_EN.
// ---------------------------------------------------------------------------
interface rc5_decrypt_core_if;
   import rc5_pkg::*;

   logic          iStart;
   logic [W-1:0]  iA;
   logic [W-1:0]  iB;
   logic [AW-1:0] oS_address;
   logic [W-1:0]  iS_sub_i;
   logic [W-1:0]  oA;
   logic [W-1:0]  oB;
   logic          oBusy;
   logic          oDone;

`ifdef RC5_ENC_EN
   logic          iEncrypt;

   modport master (output iStart, iA, iB, iEncrypt, iS_sub_i,
                   input  oS_address, oA, oB, oBusy, oDone);
   modport slave  (input  iStart, iA, iB, iEncrypt, iS_sub_i,
                   output oS_address, oA, oB, oBusy, oDone);
`else
   modport master (output iStart, iA, iB, iS_sub_i,
                   input  oS_address, oA, oB, oBusy, oDone);
   modport slave  (input  iStart, iA, iB, iS_sub_i,
                   output oS_address, oA, oB, oBusy, oDone);
`endif

endinterface

// File: rtl/rc5_rotator.sv
// ---------------------------------------------------------------------------
// rc5_rotator
// Combinational W-bit barrel rotator.
//   iData    word to rotate
//   iAmount  rotate distance (ROT_BITS LSBs of the rotate source)
//   iDir     0 = rotate left, 1 = rotate right
//   oData    rotated word
// ---------------------------------------------------------------------------
module rc5_rotator
   import rc5_pkg::*;
(
   input  logic [W-1:0]        iData,
   input  logic [ROT_BITS-1:0] iAmount,
   input  logic                iDir,
   output logic [W-1:0]        oData
);

   logic [W-1:0] w_rol;
   logic [W-1:0] w_ror;
   int           w_comp;

   // A complementary shift of W bits yields zero, so amount 0 passes through.
   assign w_comp = W - int'(iAmount);
   assign w_rol  = (iData << iAmount) | (iData >> w_comp);
   assign w_ror  = (iData >> iAmount) | (iData << w_comp);
   assign oData  = iDir ? w_ror : w_rol;

endmodule

// File: rtl/rc5_decrypt_core.sv
// ---------------------------------------------------------------------------
// rc5_decrypt_core
// Reads the expanded key table S back from the S RAM and runs RC5-W/R
// decryption on one two-word block. One S word is fetched per ADDR_* state
// and consumed in the following CALC/FIN state (read latency one cycle).
//   clk, rst    clock, synchronous active-high reset
//   bus (slave) request iStart/iA/iB, S RAM port oS_address/iS_sub_i,
//               result oA/oB, status oBusy/oDone
// Optional build macro: RC5_ENC_EN adds bus.iEncrypt; with it high the
// encrypt sequence runs (whitening first, ascending addresses).
// ---------------------------------------------------------------------------
module rc5_decrypt_core
   import rc5_pkg::*;
(
   input  logic           clk,
   input  logic           rst,
   rc5_decrypt_core_if.slave bus
);

   state_t              r_state;
   state_t              w_next;
   logic [AW-1:0]       r_cnt;
   logic [AW-1:0]       w_cnt_nxt;
   logic [W-1:0]        r_a;
   logic [W-1:0]        r_b;
   logic [W-1:0]        w_a_nxt;
   logic [W-1:0]        w_b_nxt;
   logic [W-1:0]        r_oa;
   logic [W-1:0]        r_ob;
   logic [W-1:0]        w_rot_in;
   logic [W-1:0]        w_rot_out;
   logic [ROT_BITS-1:0] w_rot_amt;
   logic                w_enc;
   logic                w_enc_in;

`ifdef RC5_ENC_EN
   logic r_enc;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_enc <= 1'b0;
      end else if (r_state == IDLE && bus.iStart) begin
         r_enc <= bus.iEncrypt;
      end
   end

   assign w_enc_in = bus.iEncrypt;
   assign w_enc    = r_enc;
`else
   assign w_enc_in = 1'b0;
   assign w_enc    = 1'b0;
`endif

   // Both directions rotate by A in the B step and by B in the A step.
   always_comb begin
      w_rot_amt = (r_state == CALC_B) ? r_a[ROT_BITS-1:0] : r_b[ROT_BITS-1:0];
      w_rot_in  = (r_state == CALC_B) ? (r_b - bus.iS_sub_i) : (r_a - bus.iS_sub_i);
      if (w_enc) begin
         w_rot_in = r_a ^ r_b;
      end
   end

   rc5_rotator u_rot (
      .iData   (w_rot_in),
      .iAmount (w_rot_amt),
      .iDir    (~w_enc),
      .oData   (w_rot_out)
   );

   // The counter doubles as the RAM address; it only moves on edges that
   // enter an ADDR_* state, so the address is stable everywhere else.
   always_comb begin
      w_next    = r_state;
      w_cnt_nxt = r_cnt;
      w_a_nxt   = r_a;
      w_b_nxt   = r_b;
      case (r_state)
         IDLE: begin
            if (bus.iStart) begin
               w_a_nxt = bus.iA;
               w_b_nxt = bus.iB;
               if (w_enc_in) begin
                  w_next    = ADDR_F0;
                  w_cnt_nxt = '0;
               end else begin
                  w_next    = ADDR_B;
                  w_cnt_nxt = START_ADDR;
               end
            end
         end
         ADDR_B:  w_next = CALC_B;
         CALC_B: begin
            if (w_enc) begin
               w_b_nxt = w_rot_out + bus.iS_sub_i;
               if (r_cnt == START_ADDR) begin
                  w_next = DONE;
               end else begin
                  w_next    = ADDR_A;
                  w_cnt_nxt = r_cnt + 1'b1;
               end
            end else begin
               w_b_nxt   = w_rot_out ^ r_a;
               w_next    = ADDR_A;
               w_cnt_nxt = r_cnt - 1'b1;
            end
         end
         ADDR_A:  w_next = CALC_A;
         CALC_A: begin
            w_cnt_nxt = w_enc ? (r_cnt + 1'b1) : (r_cnt - 1'b1);
            if (w_enc) begin
               w_a_nxt = w_rot_out + bus.iS_sub_i;
               w_next  = ADDR_B;
            end else begin
               w_a_nxt = w_rot_out ^ r_b;
               w_next  = (r_cnt == FINAL_ADDR) ? ADDR_F1 : ADDR_B;
            end
         end
         ADDR_F1: w_next = FIN_B;
         FIN_B: begin
            if (w_enc) begin
               w_b_nxt   = r_b + bus.iS_sub_i;
               w_next    = ADDR_A;
               w_cnt_nxt = r_cnt + 1'b1;
            end else begin
               w_b_nxt   = r_b - bus.iS_sub_i;
               w_next    = ADDR_F0;
               w_cnt_nxt = r_cnt - 1'b1;
            end
         end
         ADDR_F0: w_next = FIN_A;
         FIN_A: begin
            if (w_enc) begin
               w_a_nxt   = r_a + bus.iS_sub_i;
               w_next    = ADDR_F1;
               w_cnt_nxt = r_cnt + 1'b1;
            end else begin
               w_a_nxt = r_a - bus.iS_sub_i;
               w_next  = DONE;
            end
         end
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_oa    <= '0;
         r_ob    <= '0;
      end else begin
         r_state <= w_next;
         r_cnt   <= w_cnt_nxt;
         // Result registers load together with the last working-word update.
         if (w_next == DONE) begin
            r_oa <= w_a_nxt;
            r_ob <= w_b_nxt;
         end
      end
   end

   always_ff @(posedge clk) begin
      r_a <= w_a_nxt;
      r_b <= w_b_nxt;
   end

   assign bus.oS_address = r_cnt;
   assign bus.oA         = r_oa;
   assign bus.oB         = r_ob;
   assign bus.oBusy      = (r_state != IDLE);
   assign bus.oDone      = (r_state == DONE);

endmodule

// File: tb/tb_rc5_decrypt_core.sv
// ---------------------------------------------------------------------------
// tb_rc5_decrypt_core
// Randomized scoreboard bench: each issued block pushes its reference
// result (computed from the RC5 definition) into a queue; a monitor pops
// and compares whenever oDone is seen. The stimulus side also checks
// latency, address sequence, oBusy, hold of outputs, ignored iStart and
// reset. Optional build macro: RC5_ENC_EN enables the encrypt tests.
// ---------------------------------------------------------------------------
module tb_rc5_decrypt_core;
   import rc5_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   rc5_decrypt_core_if bus();

   rc5_decrypt_core dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [W-1:0]   s_tab [T];
   logic [2*W-1:0] sb_q [$];
   logic [2*W-1:0] last_res;
   logic [AW-1:0]  addr_tr [0:127];
   logic           busy_tr [0:127];
   int             n_vec = 0;
   int             n_mis = 0;

   // synchronous-read S RAM
   always @(posedge clk) bus.iS_sub_i <= s_tab[bus.oS_address];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input int k);
      int m;
      m = k % W;
      if (m == 0) return x;
      return (x << m) | (x >> (W - m));
   endfunction

   function automatic logic [W-1:0] rotr(input logic [W-1:0] x, input int k);
      return rotl(x, W - (k % W));
   endfunction

   function automatic logic [2*W-1:0] model_dec(input logic [W-1:0] a_in, input logic [W-1:0] b_in);
      logic [W-1:0] a, b;
      a = a_in;
      b = b_in;
      for (int i = R; i >= 1; i--) begin
         b = rotr(b - s_tab[2*i+1], int'(a % W)) ^ a;
         a = rotr(a - s_tab[2*i],   int'(b % W)) ^ b;
      end
      b = b - s_tab[1];
      a = a - s_tab[0];
      return {a, b};
   endfunction

   function automatic logic [2*W-1:0] model_enc(input logic [W-1:0] a_in, input logic [W-1:0] b_in);
      logic [W-1:0] a, b;
      a = a_in + s_tab[0];
      b = b_in + s_tab[1];
      for (int i = 1; i <= R; i++) begin
         a = rotl(a ^ b, int'(b % W)) + s_tab[2*i];
         b = rotl(b ^ a, int'(a % W)) + s_tab[2*i+1];
      end
      return {a, b};
   endfunction

   // RC5 key schedule for a 16-byte all-zero key
   task automatic keyexp_zero();
      logic [W-1:0] l [4];
      logic [W-1:0] a, b;
      int i, j;
      for (int k = 0; k < 4; k++) l[k] = '0;
      s_tab[0] = 32'hB7E15163;
      for (int k = 1; k < T; k++) s_tab[k] = s_tab[k-1] + 32'h9E3779B9;
      a = '0; b = '0; i = 0; j = 0;
      for (int k = 0; k < 3 * T; k++) begin
         s_tab[i] = rotl(s_tab[i] + a + b, 3);
         a = s_tab[i];
         l[j] = rotl(l[j] + a + b, int'((a + b) % W));
         b = l[j];
         i = (i + 1) % T;
         j = (j + 1) % 4;
      end
   endtask

   task automatic rand_s();
      for (int k = 0; k < T; k++) s_tab[k] = $urandom;
   endtask

   // Called at a negedge with the core idle; returns at the negedge of the
   // cycle after DONE (or after the reset recovery).
   task automatic run_block(input logic [W-1:0] a, input logic [W-1:0] b, input logic enc,
                            input logic [2*W-1:0] exp, input bit pulses, input int rst_at);
      int done_cyc, nbad_a, nbad_b, m, ea;
      bus.iStart = 1'b1;
      bus.iA     = a;
      bus.iB     = b;
`ifdef RC5_ENC_EN
      bus.iEncrypt = enc;
`endif
      sb_q.push_back(exp);
      @(posedge clk);
      done_cyc = -1;
      for (int c = 1; c <= 100; c++) begin
         @(negedge clk);
         bus.iStart = pulses && (c == 10 || c == 30);
         if (bus.iStart) bus.iA = ~a;
         addr_tr[c] = bus.oS_address;
         busy_tr[c] = bus.oBusy;
         if (c == 30) check("hold_out", {bus.oA, bus.oB}, last_res);
         if (c == rst_at) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            check("rst_outputs", {bus.oA, bus.oB, bus.oS_address, bus.oBusy, bus.oDone}, '0);
            void'(sb_q.pop_back());
            last_res = '0;
            done_cyc = 0;
            break;
         end
         if (bus.oDone) begin
            done_cyc = c;
            break;
         end
      end
      if (done_cyc != 0) begin
         check("done_cycle", done_cyc, 4*R+5);
         if (done_cyc < 0) sb_q.delete();
         nbad_a = 0;
         nbad_b = 0;
         for (int c = 1; c <= 4*R+5 && done_cyc > 0; c++) begin
            m  = ((c - 1) / 2 < T - 1) ? (c - 1) / 2 : T - 1;
            ea = enc ? m : T - 1 - m;
            if (int'(addr_tr[c]) != ea) nbad_a++;
            if (busy_tr[c] !== 1'b1) nbad_b++;
         end
         check("addr_sequence", nbad_a, 0);
         check("busy_window", nbad_b, 0);
         last_res = exp;
      end
      @(negedge clk);
      check("idle_after", {bus.oBusy, bus.oDone}, 2'b00);
   endtask

   // scoreboard monitor
   initial begin
      forever begin
         @(negedge clk);
         if (bus.oDone === 1'b1) begin
            if (sb_q.size() == 0) begin
               n_vec++;
               n_mis++;
               $display("FAIL unexpected_done: oA=0x%0h oB=0x%0h, no block outstanding", bus.oA, bus.oB);
            end else begin
               check("result", {bus.oA, bus.oB}, sb_q.pop_front());
            end
         end
      end
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [W-1:0] a, b;
      logic [2*W-1:0] ct;
      rst       = 1'b1;
      bus.iStart = 1'b0;
      bus.iA    = '0;
      bus.iB    = '0;
`ifdef RC5_ENC_EN
      bus.iEncrypt = 1'b0;
`endif
      last_res  = '0;
      for (int k = 0; k < T; k++) s_tab[k] = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_state", {bus.oA, bus.oB, bus.oS_address, bus.oBusy, bus.oDone}, '0);
      rst = 1'b0;
      @(negedge clk);

      // all-zero table, zero block
      run_block('0, '0, 1'b0, '0, 1'b0, 0);

      // zero-key table, known ciphertext
      keyexp_zero();
      check("kat_model", model_dec(32'hEEDBA521, 32'h6D8F4B15), '0);
      run_block(32'hEEDBA521, 32'h6D8F4B15, 1'b0, {32'h0, 32'h0}, 1'b0, 0);

      // random block, then ignored iStart pulses with output hold check
      rand_s();
      a = $urandom; b = $urandom;
      run_block(a, b, 1'b0, model_dec(a, b), 1'b0, 0);
      a = $urandom; b = $urandom;
      run_block(a, b, 1'b0, model_dec(a, b), 1'b1, 0);

      // reset in cycle 20, then a fresh block
      a = $urandom; b = $urandom;
      run_block(a, b, 1'b0, model_dec(a, b), 1'b0, 20);
      a = $urandom; b = $urandom;
      run_block(a, b, 1'b0, model_dec(a, b), 1'b0, 0);

      // rotate amount 0 / 31 on both words, upper bits random
      for (int k = 0; k < 4; k++) begin
         rand_s();
         a = $urandom; b = $urandom;
         a[4:0] = k[0] ? 5'd31 : 5'd0;
         b[4:0] = k[1] ? 5'd31 : 5'd0;
         run_block(a, b, 1'b0, model_dec(a, b), 1'b0, 0);
      end
      // first A-step rotate amount also forced to 0
      a = $urandom; b = $urandom;
      a[4:0] = 5'd0;
      s_tab[T-1] = b - ($urandom & 32'hFFFF_FFE0);
      run_block(a, b, 1'b0, model_dec(a, b), 1'b0, 0);

      // random blocks
      for (int k = 0; k < 150; k++) begin
         if (k % 10 == 0) rand_s();
         a = $urandom; b = $urandom;
         run_block(a, b, 1'b0, model_dec(a, b), 1'b0, 0);
      end

`ifdef RC5_ENC_EN
      keyexp_zero();
      run_block('0, '0, 1'b1, {32'hEEDBA521, 32'h6D8F4B15}, 1'b0, 0);
      run_block(32'hEEDBA521, 32'h6D8F4B15, 1'b0, '0, 1'b0, 0);
      for (int k = 0; k < 300; k++) begin
         if (k % 20 == 0) rand_s();
         a = $urandom; b = $urandom;
         ct = model_enc(a, b);
         run_block(a, b, 1'b1, ct, 1'b0, 0);
         run_block(ct[2*W-1:W], ct[W-1:0], 1'b0, {a, b}, 1'b0, 0);
      end
`endif

      repeat (5) @(negedge clk);
      check("scoreboard_drained", sb_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
